// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle multiply/divide unit beside the EX-stage ALU.
// Multiplies finish after MUL_CYCLES cycles. Divides take WIDTH restoring
// iterations plus one sign fix-up cycle. HI/LO come back as a one-cycle
// whilo pulse in DONE.
module ex_muldiv #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             whilo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam int W    = WIDTH;
  localparam int CMAX = (W > MUL_CYCLES) ? W : MUL_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(W - 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MADD  = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t r_state, w_nxt;

  logic [2:0]    r_op;
  logic [W-1:0]  r_a, r_b, r_hin, r_lin;
  logic [W-1:0]  r_rem, r_quo, r_dvs;
  logic          r_qneg, r_rneg;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_hi, r_lo;
  logic          r_dz;

  logic          w_valid_op, w_is_div, w_accept;
  logic          w_a_neg, w_b_neg;
  logic [W-1:0]  w_a_mag, w_b_mag;
  logic [2*W-1:0] w_sx_a, w_sx_b, w_sprod, w_uprod, w_hilo, w_mres;
  logic [W:0]    w_trial;
  logic [W-1:0]  w_fix_q, w_fix_r;
  logic [W-1:0]  w_res_hi, w_res_lo;
  logic          w_res_dz;

  assign w_valid_op = (op_i != 3'b000) && (op_i != 3'b111);
  assign w_is_div   = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign w_accept   = (r_state == S_IDLE) && start_i && w_valid_op && !annul_i;

  // DIV works on magnitudes; signs are reapplied in FIX
  assign w_a_neg = (op_i == OP_DIV) && opa_i[W-1];
  assign w_b_neg = (op_i == OP_DIV) && opb_i[W-1];
  assign w_a_mag = w_a_neg ? -opa_i : opa_i;
  assign w_b_mag = w_b_neg ? -opb_i : opb_i;

  // Sign-extended 2W operands give the signed product modulo 2^(2W)
  assign w_sx_a  = {{W{r_a[W-1]}}, r_a};
  assign w_sx_b  = {{W{r_b[W-1]}}, r_b};
  assign w_sprod = w_sx_a * w_sx_b;
  assign w_uprod = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};
  assign w_hilo  = {r_hin, r_lin};

  // Pick the multiply-family result for the captured op
  always_comb begin
    w_mres = w_sprod;
    case (r_op)
      OP_MULTU: w_mres = w_uprod;
      OP_MADD:  w_mres = w_hilo + w_sprod;
      OP_MSUB:  w_mres = w_hilo - w_sprod;
      default:  w_mres = w_sprod;
    endcase
  end

  // One restoring step: shift in the next dividend bit and try to subtract
  assign w_trial = {r_rem, r_quo[W-1]} - {1'b0, r_dvs};
  assign w_fix_q = r_qneg ? -r_quo : r_quo;
  assign w_fix_r = r_rneg ? -r_rem : r_rem;

  // Result that gets latched into HI/LO on entry to DONE
  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    w_res_dz = 1'b0;
    case (r_state)
      S_MUL: {w_res_hi, w_res_lo} = w_mres;
      S_DIV: begin
        w_res_hi = r_a;
        w_res_lo = '1;
        w_res_dz = 1'b1;
      end
      S_FIX: begin
        w_res_hi = w_fix_r;
        w_res_lo = w_fix_q;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // Next-state logic; annul drops any in-flight op except once in DONE
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_nxt = w_is_div ? S_DIV : S_MUL;
      S_MUL: begin
        if (annul_i)               w_nxt = S_IDLE;
        else if (r_cnt == MUL_LAST) w_nxt = S_DONE;
      end
      S_DIV: begin
        if (annul_i)                w_nxt = S_IDLE;
        else if (r_dvs == '0)       w_nxt = S_DONE;
        else if (r_cnt == DIV_LAST) w_nxt = S_FIX;
      end
      S_FIX:   w_nxt = annul_i ? S_IDLE : S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_hin  <= '0;
      r_lin  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_dz   <= 1'b0;
    end else begin
      r_hi <= '0;
      r_lo <= '0;
      r_dz <= 1'b0;
      if (w_nxt == S_DONE) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
        r_dz <= w_res_dz;
      end
      if (w_accept) begin
        r_op   <= op_i;
        r_a    <= opa_i;
        r_b    <= opb_i;
        r_hin  <= hi_i;
        r_lin  <= lo_i;
        r_rem  <= '0;
        r_quo  <= w_a_mag;
        r_dvs  <= w_b_mag;
        r_qneg <= w_a_neg ^ w_b_neg;
        r_rneg <= w_a_neg;
        r_cnt  <= '0;
      end else begin
        case (r_state)
          S_MUL: r_cnt <= r_cnt + 1'b1;
          S_DIV: begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_trial[W]) begin
              r_rem <= w_trial[W-1:0];
              r_quo <= {r_quo[W-2:0], 1'b1};
            end else begin
              r_rem <= {r_rem[W-2:0], r_quo[W-1]};
              r_quo <= {r_quo[W-2:0], 1'b0};
            end
          end
          default: r_cnt <= '0;
        endcase
      end
    end
  end

  assign busy_o     = w_accept || (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
  assign done_o     = (r_state == S_DONE);
  assign whilo_o    = done_o;
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;
  assign div_zero_o = r_dz;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: drives a 32-bit and an 8-bit ex_muldiv from shared inputs
// (separate start lines), with hand vectors, corner sequences and random ops.
module tb_ex_muldiv;
  localparam int MC32 = 3;
  localparam int MC8  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, start8, annul;
  logic [2:0]  op;
  logic [63:0] a, b, hi, lo;

  logic        busy32, done32, whilo32, dz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, whilo8, dz8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(32), .MUL_CYCLES(MC32)) u32 (
    .clk(clk), .rst(rst), .start_i(start32), .op_i(op),
    .opa_i(a[31:0]), .opb_i(b[31:0]), .hi_i(hi[31:0]), .lo_i(lo[31:0]),
    .annul_i(annul), .busy_o(busy32), .done_o(done32), .whilo_o(whilo32),
    .hi_o(hi32), .lo_o(lo32), .div_zero_o(dz32));

  ex_muldiv #(.WIDTH(8), .MUL_CYCLES(MC8)) u8 (
    .clk(clk), .rst(rst), .start_i(start8), .op_i(op),
    .opa_i(a[7:0]), .opb_i(b[7:0]), .hi_i(hi[7:0]), .lo_i(lo[7:0]),
    .annul_i(annul), .busy_o(busy8), .done_o(done8), .whilo_o(whilo8),
    .hi_o(hi8), .lo_o(lo8), .div_zero_o(dz8));

  function automatic logic [63:0] o_busy(int w);  return (w == 32) ? 64'(busy32)  : 64'(busy8);  endfunction
  function automatic logic [63:0] o_done(int w);  return (w == 32) ? 64'(done32)  : 64'(done8);  endfunction
  function automatic logic [63:0] o_whilo(int w); return (w == 32) ? 64'(whilo32) : 64'(whilo8); endfunction
  function automatic logic [63:0] o_dz(int w);    return (w == 32) ? 64'(dz32)    : 64'(dz8);    endfunction
  function automatic logic [63:0] o_hi(int w);    return (w == 32) ? 64'(hi32)    : 64'(hi8);    endfunction
  function automatic logic [63:0] o_lo(int w);    return (w == 32) ? 64'(lo32)    : 64'(lo8);    endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the architectural rules
  task automatic model(input int w, input logic [2:0] op_, input logic [63:0] a_, b_, hi_, lo_,
                       output logic [63:0] ehi, output logic [63:0] elo, output logic edz,
                       output int lat);
    logic [127:0] m1, m2, ua, ub, acc, res, th, tl;
    logic signed [127:0] sa, sb, q, r;
    m1  = (128'd1 << w) - 128'd1;
    m2  = (128'd1 << (2 * w)) - 128'd1;
    ua  = {64'd0, a_} & m1;
    ub  = {64'd0, b_} & m1;
    acc = ((({64'd0, hi_} & m1) << w) | ({64'd0, lo_} & m1));
    sa  = ua[w-1] ? $signed(ua - (128'd1 << w)) : $signed(ua);
    sb  = ub[w-1] ? $signed(ub - (128'd1 << w)) : $signed(ub);
    edz = 1'b0;
    lat = (w == 32) ? MC32 : MC8;
    res = '0;
    th  = '0;
    tl  = '0;
    case (op_)
      3'd1: res = $unsigned(sa * sb) & m2;
      3'd2: res = (ua * ub) & m2;
      3'd5: res = (acc + $unsigned(sa * sb)) & m2;
      3'd6: res = (acc - $unsigned(sa * sb)) & m2;
      default: ;
    endcase
    th = (res >> w) & m1;
    tl = res & m1;
    if (op_ == 3'd3 || op_ == 3'd4) begin
      if (ub == 0) begin
        tl = m1; th = ua; edz = 1'b1; lat = 1;
      end else begin
        lat = w + 1;
        if (op_ == 3'd4) begin
          tl = ua / ub; th = ua % ub;
        end else begin
          q = sa / sb; r = sa % sb;
          tl = $unsigned(q) & m1; th = $unsigned(r) & m1;
        end
      end
    end
    ehi = th[63:0];
    elo = tl[63:0];
  endtask

  // Present an op at a negedge and follow it cycle by cycle to the result
  task automatic run_op(input string nm, input int w, input logic [2:0] op_,
                        input logic [63:0] a_, b_, hi_, lo_, ehi, elo,
                        input logic edz, input int lat, input bit annul_done);
    op = op_; a = a_; b = b_; hi = hi_; lo = lo_;
    start32 = (w == 32); start8 = (w == 8);
    #1 chk({nm, ":acc_busy"}, o_busy(w), 64'd1);
    for (int m = 0; m <= lat; m++) begin
      @(negedge clk);
      if (m < lat) begin
        chk({nm, ":busy"}, o_busy(w), 64'd1);
        chk({nm, ":early_done"}, o_done(w), 64'd0);
        chk({nm, ":hi_idle"}, o_hi(w), 64'd0);
      end else begin
        if (annul_done) begin annul = 1'b1; #1; end
        chk({nm, ":done"}, o_done(w), 64'd1);
        chk({nm, ":whilo"}, o_whilo(w), 64'd1);
        chk({nm, ":busy_done"}, o_busy(w), 64'd0);
        chk({nm, ":hi"}, o_hi(w), ehi);
        chk({nm, ":lo"}, o_lo(w), elo);
        chk({nm, ":dz"}, o_dz(w), 64'(edz));
      end
    end
    start32 = 1'b0; start8 = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    chk({nm, ":after_done"}, o_done(w), 64'd0);
    chk({nm, ":after_busy"}, o_busy(w), 64'd0);
    chk({nm, ":after_hilo"}, o_hi(w) | o_lo(w) | o_dz(w) | o_whilo(w), 64'd0);
  endtask

  task automatic run_model(input string nm, input int w, input logic [2:0] op_,
                           input logic [63:0] a_, b_, hi_, lo_);
    logic [63:0] eh, el;
    logic ez;
    int lt;
    model(w, op_, a_, b_, hi_, lo_, eh, el, ez, lt);
    run_op(nm, w, op_, a_, b_, hi_, lo_, eh, el, ez, lt, 1'b0);
  endtask

  // Start DIVU 100/7, kill it with annul and/or rst after n cycles in flight
  task automatic abort_div(input string nm, input int w, input int n, input bit use_rst, input bit use_annul);
    int sp;
    op = 3'd4; a = 64'd100; b = 64'd7; hi = 0; lo = 0;
    start32 = (w == 32); start8 = (w == 8);
    for (int m = 0; m < n; m++) @(negedge clk);
    rst = use_rst; annul = use_annul; start32 = 1'b0; start8 = 1'b0;
    @(negedge clk);
    rst = 1'b0; annul = 1'b0;
    chk({nm, ":busy"}, o_busy(w), 64'd0);
    chk({nm, ":done"}, o_done(w), 64'd0);
    chk({nm, ":outs"}, o_hi(w) | o_lo(w) | o_dz(w) | o_whilo(w), 64'd0);
    run_model({nm, ":multu_next"}, w, 3'd2, 64'd6, 64'd7, 64'd0, 64'd0);
    sp = 0;
    for (int m = 0; m < 40; m++) begin
      @(negedge clk);
      if (o_done(w) != 0) sp++;
    end
    chk({nm, ":no_late_done"}, 64'(sp), 64'd0);
  endtask

  typedef struct {
    int w; logic [2:0] op;
    logic [63:0] a, b, hi, lo, ehi, elo;
    logic edz; int lat;
  } vec_t;

  function automatic logic [63:0] rnd(int w);
    logic [63:0] v, m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = m;
      2: v = 64'd1 << (w - 1);
      3: v = 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v & m;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    int sp, w;
    logic [2:0] rop;

    rst = 1'b1; start32 = 0; start8 = 0; annul = 0; op = 0; a = 0; b = 0; hi = 0; lo = 0;
    repeat (3) @(negedge clk);
    foreach (tbl[i]) ;
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 32 : 8;
      chk("reset:done", o_done(w), 64'd0);
      chk("reset:busy", o_busy(w), 64'd0);
      chk("reset:outs", o_hi(w) | o_lo(w) | o_dz(w) | o_whilo(w), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    tbl.push_back('{32, 3'd1, 64'hFFFFFFFD, 64'd5, 0, 0, 64'hFFFFFFFF, 64'hFFFFFFF1, 1'b0, 3});
    tbl.push_back('{32, 3'd4, 64'd100, 64'd7, 0, 0, 64'd2, 64'd14, 1'b0, 33});
    tbl.push_back('{32, 3'd3, 64'hFFFFFFF9, 64'd2, 0, 0, 64'hFFFFFFFF, 64'hFFFFFFFD, 1'b0, 33});
    tbl.push_back('{32, 3'd3, 64'h80000000, 64'hFFFFFFFF, 0, 0, 64'd0, 64'h80000000, 1'b0, 33});
    tbl.push_back('{32, 3'd3, 64'd5, 64'd0, 0, 0, 64'd5, 64'hFFFFFFFF, 1'b1, 1});
    tbl.push_back('{32, 3'd4, 64'd7, 64'd0, 0, 0, 64'd7, 64'hFFFFFFFF, 1'b1, 1});
    tbl.push_back('{32, 3'd5, 64'd1, 64'd1, 64'd0, 64'hFFFFFFFF, 64'd1, 64'd0, 1'b0, 3});
    tbl.push_back('{32, 3'd6, 64'd2, 64'd3, 64'd0, 64'd0, 64'hFFFFFFFF, 64'hFFFFFFFA, 1'b0, 3});
    tbl.push_back('{32, 3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, 0, 64'hFFFFFFFE, 64'h00000001, 1'b0, 3});
    tbl.push_back('{8, 3'd1, 64'hFD, 64'h05, 0, 0, 64'hFF, 64'hF1, 1'b0, 1});
    tbl.push_back('{8, 3'd4, 64'd100, 64'd7, 0, 0, 64'h02, 64'h0E, 1'b0, 9});
    tbl.push_back('{8, 3'd3, 64'h80, 64'hFF, 0, 0, 64'h00, 64'h80, 1'b0, 9});
    tbl.push_back('{8, 3'd3, 64'hF9, 64'h02, 0, 0, 64'hFF, 64'hFD, 1'b0, 9});
    tbl.push_back('{8, 3'd3, 64'h07, 64'hFE, 0, 0, 64'h01, 64'hFD, 1'b0, 9});
    tbl.push_back('{8, 3'd5, 64'hFF, 64'h01, 64'h7F, 64'hFF, 64'h7F, 64'hFE, 1'b0, 1});
    tbl.push_back('{8, 3'd3, 64'h80, 64'h00, 0, 0, 64'h80, 64'hFF, 1'b1, 1});

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].w, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi,
             tbl[i].lo, tbl[i].ehi, tbl[i].elo, tbl[i].edz, tbl[i].lat, i == 1);

    // no-op codes and annul in IDLE are never accepted
    for (int k = 0; k < 3; k++) begin
      op = (k == 0) ? 3'd0 : (k == 1) ? 3'd7 : 3'd2;
      annul = (k == 2);
      a = 64'd3; b = 64'd4; start32 = 1'b1; start8 = 1'b1;
      #1 chk("noacc:busy32", o_busy(32), 64'd0);
      chk("noacc:busy8", o_busy(8), 64'd0);
      sp = 0;
      for (int m = 0; m < 6; m++) begin
        @(negedge clk);
        if (o_busy(32) != 0 || o_done(32) != 0 || o_busy(8) != 0 || o_done(8) != 0) sp++;
      end
      chk("noacc:activity", 64'(sp), 64'd0);
      start32 = 1'b0; start8 = 1'b0; annul = 1'b0;
      @(negedge clk);
    end

    abort_div("annul32", 32, 10, 1'b0, 1'b1);
    abort_div("rst32", 32, 10, 1'b1, 1'b0);
    abort_div("rstannul32", 32, 20, 1'b1, 1'b1);
    abort_div("annul8_fix", 8, 9, 1'b0, 1'b1);
    abort_div("annul8", 8, 4, 1'b0, 1'b1);

    for (int t = 0; t < 80; t++) begin
      w = ($urandom_range(0, 1) == 0) ? 32 : 8;
      rop = 3'($urandom_range(1, 6));
      run_model($sformatf("rnd%0d", t), w, rop, rnd(w), rnd(w), rnd(w), rnd(w));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
